serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle, parametrised N-bit subtractor built from chained full-subtractor cells. It computes `diff = a - b - bin` over `WIDTH/DIGIT` clock cycles and processes `DIGIT` bits per cycle, LSB first, through a registered borrow. It sits in the arithmetic library as the sequential successor to the single-bit full subtractor. Area scales with `DIGIT`, not `WIDTH`. A start/done handshake lets a controller launch an operation and collect the result.

## Interface
- `WIDTH`, default 8: operand and result width. Must be ≥ 2.
- `DIGIT`, default 1: bits processed per cycle. Must be ≥ 1 and divide `WIDTH`. `STEPS = WIDTH/DIGIT`.
- `clk`  in  1: single clock, all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: launch request, sampled on rising edge.
- `a`  in  WIDTH: minuend, captured when `start` is accepted.
- `b`  in  WIDTH: subtrahend, captured when `start` is accepted.
- `bin`  in  1: borrow-in, captured when `start` is accepted.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse, result valid.
- `diff`  out  WIDTH: result, held until the next accepted start.
- `bout`  out  1: borrow-out of the MSB, held with `diff`.
- `ovf`  out  1: signed overflow. Present only with `SUB_OVF_EN`.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE**
  - With `start=1`: latch `a`, `b` and `bin` into internal shift registers, clear the step counter, and go to RUN.
  - Also clear `diff`, `bout` and `ovf` to 0.
- **RUN**, each edge:
  - Take the low `DIGIT` bits of the operand registers and the borrow register.
  - Ripple them through `DIGIT` full-subtractor cells:
    - `d = x ^ y ^ br`
    - `br' = (~x & y) | (~(x ^ y) & br)`
  - Shift the operand registers right by `DIGIT`.
  - Shift the `d` bits into the result register from the MSB side.
  - Update the borrow register with the last `br'` and increment the counter.
  - On the edge that processes step `STEPS-1`, go to DONE.
- **DONE**
  - `done=1` for exactly one cycle, then go to IDLE unconditionally.
  - `diff` equals `(a - b - bin) mod 2^WIDTH`.
  - `bout` is 1 iff `a < b + bin` (unsigned).
- Arithmetic is pure modulo `2^WIDTH`. No saturation.
- `start` in RUN or DONE is ignored. There is no queueing.
- `a`, `b` and `bin` may change freely after the accepting edge.
- Async reset mid-operation:
  - Immediately: `busy=0`, `done=0`, `diff=0`, `bout=0`, `ovf=0`, state IDLE.
  - The partial result is discarded.
- The counter is `$clog2(STEPS)` bits, minimum 1. It never wraps within an operation.

## Timing
- Reset values: `busy=0`, `done=0`, `diff=0`, `bout=0`, `ovf=0`.
- Edge E0 samples `start=1` in IDLE.
  - `busy` rises after E0.
  - Steps are processed on edges E1 through E`STEPS`.
- `busy` falls and `done` rises after edge E`STEPS`. `done` falls after E`STEPS+1`.
- Start-to-done latency is `STEPS` edges after the accepting edge.
- Earliest next accept is E`STEPS+2`, when `start` is sampled back in IDLE.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `diff`, `bout` and `ovf` are stable from the `done` pulse until the next accepted start clears them.

## Configuration
- `SUB_OVF_EN` defined:
  - Port `ovf` exists.
  - It is registered and updated on the final RUN edge together with `diff`.
  - `ovf` = (borrow into the MSB cell) XOR (borrow out of the MSB cell), i.e. signed two's-complement overflow of `a - b - bin`.
  - An extra 1-bit register keeps the MSB borrow-in.
- `SUB_OVF_EN` undefined: port `ovf` and its logic are absent. All other behaviour is identical.

## Test plan
- Basic subtract, `WIDTH=8`, `DIGIT=1`: `a=8'h35`, `b=8'h12`, `bin=0` → `diff=8'h23`, `bout=0`. `done` pulses 8 edges after the accepting edge and `busy` is high for exactly 8 cycles.
- Underflow: `a=8'h00`, `b=8'h01`, `bin=0` → `diff=8'hFF`, `bout=1`. Then `a=8'h10`, `b=8'h0F`, `bin=1` → `diff=8'h00`, `bout=0`.
- Overflow (`SUB_OVF_EN`):
  - `a=8'h80`, `b=8'h01` → `diff=8'h7F`, `bout=0`, `ovf=1`.
  - `a=8'h7F`, `b=8'hFF` → `diff=8'h80`, `bout=1`, `ovf=1`.
  - `a=8'h05`, `b=8'h03` → `ovf=0`.
- Handshake abuse: hold `start=1` continuously for a run `a=8'h35`, `b=8'h12`, `bin=0`.
  - Exactly one operation per IDLE visit.
  - Changing `a`/`b` during RUN does not alter the result.
  - Back-to-back ops are accepted at E`STEPS+2`.
- Reset mid-operation: assert `rst_n=0` at the 4th RUN cycle.
  - All outputs go to 0 asynchronously and the state is IDLE.
  - A following op `a=8'h35`, `b=8'h12` yields `8'h23`.
- Multi-bit digit, `WIDTH=8`, `DIGIT=4`: `a=8'h00`, `b=8'h00`, `bin=1` → `diff=8'hFF`, `bout=1`, `done` pulses 2 edges after accept. Add a randomized sweep of 1000 ops against the `a - b - bin` reference model.

Source files
------------

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Start/done handshake and operand/result bundle for the
//               serial subtractor.
//               master : controller side (drives start, a, b, bin)
//               slave  : subtractor side (drives busy, done, diff, bout, ovf)
//               Signal ovf exists only when SUB_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
`endif
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Multi-cycle WIDTH-bit subtractor, diff = a - b - bin, working
//               DIGIT bits per clock LSB first through a registered borrow.
//               Takes WIDTH/DIGIT RUN cycles after the accepting edge.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - serial_subtractor_if.slave
//                        start/a/b/bin in, busy/done/diff/bout(/ovf) out
// Options     : SUB_OVF_EN - adds registered signed-overflow flag bus.ovf
// Parameters  : WIDTH >= 2, DIGIT >= 1 and must divide WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input wire                 clk,
    input wire                 rst_n,
    serial_subtractor_if.slave bus
);

    localparam int c_STEPS = WIDTH / DIGIT;
    // A single-step configuration still needs a 1-bit counter.
    localparam int c_CNT_W = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic [DIGIT-1:0]   w_d;
    logic               w_br_chain;
    logic               w_br_out;
    logic               w_last;
    logic [WIDTH-1:0]   w_diff_next;

`ifdef SUB_OVF_EN
    logic               r_ovf;
    logic               w_br_msb_in;
`endif

    assign w_last = (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // DIGIT full-subtractor cells, rippling the borrow from bit 0 upward.
    // ------------------------------------------------------------------
    always_comb begin
        w_d        = '0;
        w_br_chain = r_br;
`ifdef SUB_OVF_EN
        w_br_msb_in = r_br;
`endif
        for (int i = 0; i < DIGIT; i++) begin
`ifdef SUB_OVF_EN
            // The last iteration leaves the borrow entering the top cell;
            // on the final step that cell is the operand MSB.
            w_br_msb_in = w_br_chain;
`endif
            w_d[i]     = r_a[i] ^ r_b[i] ^ w_br_chain;
            w_br_chain = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & w_br_chain);
        end
        w_br_out = w_br_chain;
    end

    // New digit enters from the MSB side; after c_STEPS shifts the first
    // digit computed lands in the least significant position.
    assign w_diff_next = (r_diff >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
`ifdef SUB_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_br   <= bus.bin;
                        r_cnt  <= '0;
                        r_diff <= '0;
                        r_bout <= 1'b0;
`ifdef SUB_OVF_EN
                        r_ovf  <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    r_a    <= r_a >> DIGIT;
                    r_b    <= r_b >> DIGIT;
                    r_br   <= w_br_out;
                    r_diff <= w_diff_next;
                    if (w_last) begin
                        r_bout <= w_br_out;
`ifdef SUB_OVF_EN
                        r_ovf  <= w_br_msb_in ^ w_br_out;
`endif
                    end else begin
                        // Held at the last step so the counter never wraps.
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
`ifdef SUB_OVF_EN
    assign bus.ovf  = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor. Two instances:
//               u_dut1 (WIDTH=8, DIGIT=1) and u_dut4 (WIDTH=8, DIGIT=4),
//               checked against an arithmetic reference model.
// Options     : SUB_OVF_EN - also checks the ovf output
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(8)) if1 ();
    serial_subtractor_if #(.WIDTH(8)) if4 ();

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic.
    task automatic model(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                         output logic [7:0] ed, output logic eb, output logic eo);
        int u;
        int s;
        u  = int'(ta) - int'(tb_v) - int'(tbin);
        ed = u[7:0];
        eb = (u < 0);
        s  = int'($signed(ta)) - int'($signed(tb_v)) - int'(tbin);
        eo = (s < -128) || (s > 127);
    endtask

    task automatic drv(input int sel, input logic s, input logic [7:0] ta,
                       input logic [7:0] tb_v, input logic tbin);
        if (sel == 0) begin
            if1.start = s; if1.a = ta; if1.b = tb_v; if1.bin = tbin;
        end else begin
            if4.start = s; if4.a = ta; if4.b = tb_v; if4.bin = tbin;
        end
    endtask

    function automatic logic f_busy(input int sel);
        return (sel == 0) ? if1.busy : if4.busy;
    endfunction
    function automatic logic f_done(input int sel);
        return (sel == 0) ? if1.done : if4.done;
    endfunction
    function automatic logic [7:0] f_diff(input int sel);
        return (sel == 0) ? if1.diff : if4.diff;
    endfunction
    function automatic logic f_bout(input int sel);
        return (sel == 0) ? if1.bout : if4.bout;
    endfunction
`ifdef SUB_OVF_EN
    function automatic logic f_ovf(input int sel);
        return (sel == 0) ? if1.ovf : if4.ovf;
    endfunction
`endif

    // One complete operation from IDLE, checking latency, busy length,
    // clearing on accept, result and the single-cycle done pulse.
    task automatic do_op(input int sel, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tbin, input string tag);
        int         k;
        int         nb;
        int         steps;
        logic [7:0] ed;
        logic       eb;
        logic       eo;
        steps = (sel == 0) ? 8 : 2;
        model(ta, tb_v, tbin, ed, eb, eo);
        @(negedge clk);
        drv(sel, 1'b1, ta, tb_v, tbin);
        @(posedge clk); #1;
        drv(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        chk({tag, "_bout_clr"}, 32'(f_bout(sel)), 32'd0);
        chk({tag, "_diff_clr"}, 32'(f_diff(sel)), 32'd0);
        nb = f_busy(sel) ? 1 : 0;
        k  = 0;
        while (!f_done(sel) && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (f_busy(sel)) nb++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(steps));
        chk({tag, "_busy_cycles"}, 32'(nb), 32'(steps));
        chk({tag, "_diff"}, 32'(f_diff(sel)), 32'(ed));
        chk({tag, "_bout"}, 32'(f_bout(sel)), 32'(eb));
`ifdef SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(f_ovf(sel)), 32'(eo));
`endif
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, 32'(f_done(sel)), 32'd0);
        chk({tag, "_diff_hold"}, 32'(f_diff(sel)), 32'(ed));
    endtask

    initial begin
        int ndone;
        int k;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drv(0, 1'b0, 8'h00, 8'h00, 1'b0);
        drv(1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy1", 32'(if1.busy), 32'd0);
        chk("rst_done1", 32'(if1.done), 32'd0);
        chk("rst_diff1", 32'(if1.diff), 32'd0);
        chk("rst_bout1", 32'(if1.bout), 32'd0);
        chk("rst_busy4", 32'(if4.busy), 32'd0);
        chk("rst_diff4", 32'(if4.diff), 32'd0);
`ifdef SUB_OVF_EN
        chk("rst_ovf1", 32'(if1.ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_op(0, 8'h35, 8'h12, 1'b0, "basic");
        do_op(0, 8'h00, 8'h01, 1'b0, "underflow");
        do_op(0, 8'h10, 8'h0F, 1'b1, "borrow_in");
        do_op(0, 8'h80, 8'h01, 1'b0, "ovf_neg");
        do_op(0, 8'h7F, 8'hFF, 1'b0, "ovf_pos");
        do_op(0, 8'h05, 8'h03, 1'b0, "no_ovf");
        do_op(1, 8'h00, 8'h00, 1'b1, "digit4");

        // Start held high across a whole operation
        @(negedge clk);
        drv(0, 1'b1, 8'h35, 8'h12, 1'b0);
        @(posedge clk); #1;
        chk("hold_acc_busy", 32'(if1.busy), 32'd1);
        ndone = 0;
        for (int e = 1; e <= 10; e++) begin
            if (e <= 8) drv(0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            else        drv(0, 1'b1, 8'h00, 8'h01, 1'b0);
            @(posedge clk); #1;
            if (if1.done) ndone++;
            if (e == 8) begin
                chk("hold_done", 32'(if1.done), 32'd1);
                chk("hold_diff", 32'(if1.diff), 32'h23);
                chk("hold_bout", 32'(if1.bout), 32'd0);
            end
            if (e == 9)  chk("hold_no_accept_in_done", 32'(if1.busy), 32'd0);
            if (e == 10) chk("hold_reaccept", 32'(if1.busy), 32'd1);
        end
        chk("hold_one_done", 32'(ndone), 32'd1);
        drv(0, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
        k = 0;
        while (!if1.done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("b2b_latency", 32'(k), 32'd8);
        chk("b2b_diff", 32'(if1.diff), 32'hFF);
        chk("b2b_bout", 32'(if1.bout), 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset in the 4th RUN cycle
        @(negedge clk);
        drv(0, 1'b1, 8'h35, 8'h12, 1'b0);
        @(posedge clk); #1;
        drv(0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(if1.busy), 32'd0);
        chk("arst_done", 32'(if1.done), 32'd0);
        chk("arst_diff", 32'(if1.diff), 32'd0);
        chk("arst_bout", 32'(if1.bout), 32'd0);
`ifdef SUB_OVF_EN
        chk("arst_ovf", 32'(if1.ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_idle", 32'(if1.busy), 32'd0);
        do_op(0, 8'h35, 8'h12, 1'b0, "after_rst");

        // Randomized sweeps
        for (int n = 0; n < 1000; n++)
            do_op(1, 8'($urandom), 8'($urandom), 1'($urandom), "rnd4");
        for (int n = 0; n < 200; n++)
            do_op(0, 8'($urandom), 8'($urandom), 1'($urandom), "rnd1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
